// File: rtl/wb_xbar_decoder.sv
// Single-master, N-slave pipelined Wishbone interconnect with a table-driven address map.
// Unmapped addresses, slave errors and slave timeouts return a bus error; errors are counted.
module wb_xbar_decoder #(
   parameter int                    NSLAVES    = 4,
   parameter int                    AW         = 32,
   parameter int                    DW         = 32,
   parameter logic [NSLAVES*AW-1:0] SLAVE_BASE = {32'hC000_0000, 32'h8000_0000,
                                                  32'h4000_0000, 32'h0000_0000},
   parameter logic [NSLAVES*AW-1:0] SLAVE_MASK = {4{32'hC000_0000}},
   parameter int                    TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_wb_cyc,
   input  logic                  i_wb_stb,
   input  logic                  i_wb_we,
   input  logic [DW/8-1:0]       i_wb_sel,
   input  logic [AW-1:0]         i_wb_addr,
   input  logic [DW-1:0]         i_wb_data,
   output logic [DW-1:0]         o_wb_data,
   output logic                  o_wb_ack,
   output logic                  o_wb_err,
   output logic                  o_wb_stall,
   output logic [NSLAVES-1:0]    o_s_cyc,
   output logic [NSLAVES-1:0]    o_s_stb,
   output logic                  o_s_we,
   output logic [DW/8-1:0]       o_s_sel,
   output logic [AW-1:0]         o_s_addr,
   output logic [DW-1:0]         o_s_data,
   input  logic [NSLAVES*DW-1:0] i_s_data,
   input  logic [NSLAVES-1:0]    i_s_ack,
   input  logic [NSLAVES-1:0]    i_s_err,
   input  logic [NSLAVES-1:0]    i_s_stall,
   output logic [7:0]            o_err_cnt
);

   localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
   localparam int TW = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_RESP = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   // Returns {hit, index}; scanning downwards lets the lowest matching slot win.
   function automatic logic [SW:0] decode(input logic [AW-1:0] a);
      logic [SW:0] r;
      r = '0;
      for (int k = NSLAVES - 1; k >= 0; k--) begin
         if ((a & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]) begin
            r = {1'b1, SW'(k)};
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   state_t              state_r;
   state_t              next_s;
   logic [SW:0]         dec_s;
   logic [SW-1:0]       slot_s;
   logic [SW-1:0]       slv_r;
   logic [TW-1:0]       timer_r;
   logic                accept_s;
   logic                timeout_s;
   logic                s_ack_s;
   logic                s_err_s;
   logic                s_stall_s;
   logic [DW-1:0]       s_rdata_s;
   logic [NSLAVES-1:0]  s_oh_s;
   logic [NSLAVES-1:0]  s_cyc_nx_s;
   logic [NSLAVES-1:0]  s_stb_nx_s;
   logic                ack_nx_s;
   logic                err_nx_s;
   logic                stall_nx_s;
   logic [DW-1:0]       rdata_nx_s;
   logic [DW-1:0]       wb_data_r;
   logic                wb_ack_r;
   logic                wb_err_r;
   logic                wb_stall_r;
   logic [NSLAVES-1:0]  s_cyc_r;
   logic [NSLAVES-1:0]  s_stb_r;
   logic                s_we_r;
   logic [DW/8-1:0]     s_sel_r;
   logic [AW-1:0]       s_addr_r;
   logic [DW-1:0]       s_data_r;
   logic [7:0]          err_cnt_r;

   assign dec_s     = decode(i_wb_addr);
   assign accept_s  = (state_r == ST_IDLE) && i_wb_cyc && i_wb_stb;
   assign timeout_s = (timer_r == TW'(TIMEOUT - 1));
   assign s_ack_s   = i_s_ack[slv_r];
   assign s_err_s   = i_s_err[slv_r];
   assign s_stall_s = i_s_stall[slv_r];
   assign s_rdata_s = i_s_data[slv_r*DW +: DW];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic; a master abort outranks completion, and completion outranks timeout.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               next_s = dec_s[SW] ? ST_REQ : ST_ERR;
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (!i_wb_cyc) begin
               next_s = ST_IDLE;
            end else if (!s_stall_s && s_err_s) begin
               next_s = ST_ERR;
            end else if (!s_stall_s && s_ack_s) begin
               next_s = ST_RESP;
            end else if (timeout_s) begin
               next_s = ST_ERR;
            end else if (!s_stall_s) begin
               next_s = ST_WAIT;
            end else begin
               next_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (!i_wb_cyc) begin
               next_s = ST_IDLE;
            end else if (s_err_s) begin
               next_s = ST_ERR;
            end else if (s_ack_s) begin
               next_s = ST_RESP;
            end else if (timeout_s) begin
               next_s = ST_ERR;
            end else begin
               next_s = ST_WAIT;
            end
         end
         ST_RESP: next_s = ST_IDLE;
         ST_ERR:  next_s = ST_IDLE;
         default: next_s = ST_IDLE;
      endcase
   end

   // Output decode: values the output registers take on the coming edge.
   always_comb begin
      slot_s         = (state_r == ST_IDLE) ? dec_s[SW-1:0] : slv_r;
      s_oh_s         = '0;
      s_oh_s[slot_s] = 1'b1;
      s_cyc_nx_s     = '0;
      s_stb_nx_s     = '0;
      case (next_s)
         ST_REQ: begin
            s_cyc_nx_s = s_oh_s;
            s_stb_nx_s = s_oh_s;
         end
         ST_WAIT: begin
            s_cyc_nx_s = s_oh_s;
            s_stb_nx_s = '0;
         end
         default: begin
            s_cyc_nx_s = '0;
            s_stb_nx_s = '0;
         end
      endcase
      ack_nx_s   = (next_s == ST_RESP);
      stall_nx_s = (next_s != ST_IDLE);
      // The error pulse trails the ERR state by one cycle so it lands after the abandoned request.
      err_nx_s   = (state_r == ST_ERR);
      if ((next_s == ST_RESP) && !s_we_r) begin
         rdata_nx_s = s_rdata_s;
      end else begin
         rdata_nx_s = '0;
      end
   end

   // Request latch, timeout timer, registered outputs and saturating error counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slv_r      <= '0;
         timer_r    <= '0;
         s_we_r     <= 1'b0;
         s_sel_r    <= '0;
         s_addr_r   <= '0;
         s_data_r   <= '0;
         s_cyc_r    <= '0;
         s_stb_r    <= '0;
         wb_ack_r   <= 1'b0;
         wb_err_r   <= 1'b0;
         wb_stall_r <= 1'b0;
         wb_data_r  <= '0;
         err_cnt_r  <= 8'd0;
      end else begin
         if (accept_s) begin
            slv_r    <= dec_s[SW-1:0];
            s_we_r   <= i_wb_we;
            s_sel_r  <= i_wb_sel;
            s_addr_r <= i_wb_addr;
            s_data_r <= i_wb_data;
         end
         if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
            timer_r <= timer_r + TW'(1);
         end else begin
            timer_r <= '0;
         end
         s_cyc_r    <= s_cyc_nx_s;
         s_stb_r    <= s_stb_nx_s;
         wb_ack_r   <= ack_nx_s;
         wb_err_r   <= err_nx_s;
         wb_stall_r <= stall_nx_s;
         wb_data_r  <= rdata_nx_s;
         if (err_nx_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
         end
      end
   end

   assign o_wb_data  = wb_data_r;
   assign o_wb_ack   = wb_ack_r;
   assign o_wb_err   = wb_err_r;
   assign o_wb_stall = wb_stall_r;
   assign o_s_cyc    = s_cyc_r;
   assign o_s_stb    = s_stb_r;
   assign o_s_we     = s_we_r;
   assign o_s_sel    = s_sel_r;
   assign o_s_addr   = s_addr_r;
   assign o_s_data   = s_data_r;
   assign o_err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_wb_xbar_decoder.sv
// Self-checking bench: a 4-slave instance with a short timeout for directed and random
// transactions, and a 2-slave instance for unmapped-address errors and counter saturation.
module tb_wb_xbar_decoder;

   logic         clk = 1'b0;
   logic         rst_n;

   // Instance A: default map, TIMEOUT = 8
   logic         cyc, stb, we;
   logic [3:0]   sel;
   logic [31:0]  addr, wdata, rdata;
   logic         ack, err, stall;
   logic [3:0]   s_cyc, s_stb;
   logic         s_we;
   logic [3:0]   s_sel;
   logic [31:0]  s_addr, s_data;
   logic [127:0] s_rd;
   logic [3:0]   s_ack, s_err, s_stall;
   logic [7:0]   err_cnt;

   // Instance B: two slaves at 0x0000_0000 and 0x4000_0000 only
   logic         b_cyc, b_stb, b_we;
   logic [3:0]   b_sel;
   logic [31:0]  b_addr, b_wdata, b_rdata;
   logic         b_ack, b_err, b_stall;
   logic [1:0]   b_s_cyc, b_s_stb;
   logic         b_s_we;
   logic [3:0]   b_s_sel;
   logic [31:0]  b_s_addr, b_s_data;
   logic [63:0]  b_s_rd;
   logic [1:0]   b_s_ack, b_s_err, b_s_stall;
   logic [7:0]   b_err_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt_a = 0;
   int exp_cnt_b = 0;

   always #5 clk = ~clk;

   wb_xbar_decoder #(.TIMEOUT(8)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_sel(sel),
      .i_wb_addr(addr), .i_wb_data(wdata),
      .o_wb_data(rdata), .o_wb_ack(ack), .o_wb_err(err), .o_wb_stall(stall),
      .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_sel(s_sel),
      .o_s_addr(s_addr), .o_s_data(s_data),
      .i_s_data(s_rd), .i_s_ack(s_ack), .i_s_err(s_err), .i_s_stall(s_stall),
      .o_err_cnt(err_cnt)
   );

   wb_xbar_decoder #(
      .NSLAVES(2),
      .SLAVE_BASE({32'h4000_0000, 32'h0000_0000}),
      .SLAVE_MASK({2{32'hC000_0000}})
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .i_wb_cyc(b_cyc), .i_wb_stb(b_stb), .i_wb_we(b_we), .i_wb_sel(b_sel),
      .i_wb_addr(b_addr), .i_wb_data(b_wdata),
      .o_wb_data(b_rdata), .o_wb_ack(b_ack), .o_wb_err(b_err), .o_wb_stall(b_stall),
      .o_s_cyc(b_s_cyc), .o_s_stb(b_s_stb), .o_s_we(b_s_we), .o_s_sel(b_s_sel),
      .o_s_addr(b_s_addr), .o_s_data(b_s_data),
      .i_s_data(b_s_rd), .i_s_ack(b_s_ack), .i_s_err(b_s_err), .i_s_stall(b_s_stall),
      .o_err_cnt(b_err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction on instance A. Slave behaviour: stall s cycles, then
   // mode 0 = ack d cycles into WAIT, 1 = err d cycles into WAIT, 2 = never answer,
   // 3 = ack together with the first non-stalled strobe cycle.
   task automatic run_a(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] sl, input int s, input int d, input int mode,
                        input logic [31:0] rd);
      int          k, c, exp_c, stb_cnt;
      logic        done, got_ack, got_err;
      logic [31:0] got_data, exp_data;
      logic [3:0]  got_cyc, exp_oh;
      k = int'(a[31:30]);
      exp_oh = 4'b0001 << k;
      s_rd = '0;
      s_rd[k*32 +: 32] = rd;
      cyc = 1'b1; stb = 1'b1; we = w; sel = sl; addr = a; wdata = wd;
      tick();
      stb = 1'b0;
      chk("req_stb_onehot", {28'd0, s_stb}, {28'd0, exp_oh});
      chk("req_addr", s_addr, a);
      chk("req_wdata", s_data, wd);
      chk("req_we_sel", {27'd0, s_we, s_sel}, {27'd0, w, sl});
      chk("req_stall", {31'd0, stall}, 32'd1);
      c = 0; stb_cnt = 0; done = 1'b0;
      got_ack = 1'b0; got_err = 1'b0; got_data = '0; got_cyc = '0;
      while (!done && c < 20) begin
         if (s_stb != 4'd0) stb_cnt++;
         s_stall = '0; s_ack = '0; s_err = '0;
         s_stall[k] = (c < s);
         if (mode == 3) s_ack[k] = (c == s);
         if (mode == 0) s_ack[k] = (c == s + 1 + d);
         if (mode == 1) s_err[k] = (c == s + 1 + d);
         tick();
         c++;
         if (ack || err) begin
            done = 1'b1; got_ack = ack; got_err = err; got_data = rdata; got_cyc = s_cyc;
         end
      end
      s_stall = '0; s_ack = '0; s_err = '0;
      case (mode)
         0:       exp_c = s + 2 + d;
         1:       exp_c = s + 3 + d;
         2:       exp_c = 9;
         default: exp_c = s + 1;
      endcase
      exp_data = ((mode == 0 || mode == 3) && !w) ? rd : 32'd0;
      if (mode == 1 || mode == 2) exp_cnt_a = (exp_cnt_a < 255) ? exp_cnt_a + 1 : 255;
      chk("resp_latency", c, exp_c);
      chk("resp_ack_err", {30'd0, got_ack, got_err},
          {30'd0, (mode == 0 || mode == 3), (mode == 1 || mode == 2)});
      chk("resp_data", got_data, exp_data);
      chk("stb_cycles", stb_cnt, s + 1);
      chk("resp_s_cyc_idle", {28'd0, got_cyc}, 32'd0);
      chk("err_cnt_a", {24'd0, err_cnt}, exp_cnt_a);
      cyc = 1'b0;
      tick();
      chk("after_idle", {29'd0, ack, err, stall}, 32'd0);
   endtask

   initial begin
      int          pulses, guard;
      int          ks, ss, ds, ms;
      logic [31:0] ra, rw, rr;
      rst_n = 1'b0;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; addr = '0; wdata = '0;
      s_rd = '0; s_ack = '0; s_err = '0; s_stall = '0;
      b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; b_sel = '0; b_addr = '0; b_wdata = '0;
      b_s_rd = '0; b_s_ack = '0; b_s_err = '0; b_s_stall = '0;
      repeat (3) tick();
      chk("rst_wb", {29'd0, ack, err, stall}, 32'd0);
      chk("rst_slave", {24'd0, s_cyc, s_stb}, 32'd0);
      chk("rst_addr_data", s_addr | rdata, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      rst_n = 1'b1;
      tick();

      run_a(32'h0000_0010, 1'b1, 32'h1234_5678, 4'hF, 0, 0, 0, 32'hDEAD_BEEF);
      run_a(32'h4000_0004, 1'b0, 32'h0, 4'hF, 0, 0, 0, 32'hCAFE_0001);
      run_a(32'h8000_0000, 1'b0, 32'h0, 4'h3, 3, 0, 0, 32'h0BAD_F00D);
      run_a(32'hC000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 2, 32'h1111_2222);
      run_a(32'h4000_0100, 1'b0, 32'h0, 4'hF, 1, 2, 1, 32'h3333_4444);
      run_a(32'h8000_0200, 1'b0, 32'h0, 4'hF, 2, 0, 3, 32'h5555_6666);

      // Abort while waiting, then a late ack that must be ignored.
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h4000_0008;
      tick();
      stb = 1'b0;
      tick();
      cyc = 1'b0;
      tick();
      chk("abort_s_cyc", {28'd0, s_cyc}, 32'd0);
      chk("abort_stall", {31'd0, stall}, 32'd0);
      s_ack[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("late_ack_ignored", {30'd0, ack, err}, 32'd0);
      end
      s_ack = '0;
      chk("abort_err_cnt", {24'd0, err_cnt}, exp_cnt_a);

      for (int n = 0; n < 40; n++) begin
         ks = $urandom_range(0, 3);
         ss = $urandom_range(0, 3);
         ds = $urandom_range(0, 3);
         ms = $urandom_range(0, 9);
         ms = (ms <= 5) ? 0 : (ms == 6) ? 3 : (ms <= 8) ? 1 : 2;
         ra = $urandom; rw = $urandom; rr = $urandom;
         ra[31:30] = ks[1:0];
         run_a(ra, rw[0], $urandom, rw[7:4], ss, ds, ms, rr);
      end

      // Unmapped accesses on instance B.
      b_addr = 32'h8000_0000; b_cyc = 1'b1; b_stb = 1'b1;
      tick();
      b_stb = 1'b0;
      chk("unmapped_e0", {30'd0, b_err, b_stall}, 32'd1);
      tick();
      exp_cnt_b++;
      chk("unmapped_err_e1", {30'd0, b_err, b_ack}, 32'd2);
      chk("unmapped_data", b_rdata, 32'd0);
      chk("unmapped_no_cyc", {30'd0, b_s_cyc}, 32'd0);
      chk("unmapped_cnt", {24'd0, b_err_cnt}, exp_cnt_b);
      tick();
      chk("unmapped_err_1cyc", {31'd0, b_err}, 32'd0);
      b_cyc = 1'b0;
      tick();

      // Saturation: 300 back-to-back unmapped requests.
      b_addr = 32'hC000_1234; b_cyc = 1'b1; b_stb = 1'b1;
      pulses = 0; guard = 0;
      while (pulses < 300 && guard < 2000) begin
         tick();
         guard++;
         if (b_err) begin
            pulses++;
            exp_cnt_b = (exp_cnt_b < 255) ? exp_cnt_b + 1 : 255;
            chk("sat_cnt", {24'd0, b_err_cnt}, exp_cnt_b);
         end
      end
      b_cyc = 1'b0; b_stb = 1'b0;
      chk("sat_pulses", pulses, 32'd300);
      chk("sat_final", {24'd0, b_err_cnt}, 32'd255);
      repeat (3) tick();

      // Reset in the middle of a transaction.
      cyc = 1'b1; stb = 1'b1; addr = 32'h8000_0040; we = 1'b0;
      tick();
      stb = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_wb", {29'd0, ack, err, stall}, 32'd0);
      chk("midrst_slave", {24'd0, s_cyc, s_stb}, 32'd0);
      chk("midrst_cnt", {24'd0, err_cnt, b_err_cnt}, 32'd0);
      exp_cnt_a = 0;
      cyc = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      run_a(32'h0000_0020, 1'b0, 32'h0, 4'hF, 1, 1, 0, 32'h7777_8888);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
